// File: rtl/prt_vtb_tg.sv
// rtl/prt_vtb_tg.sv - Video Toolbox timing generator producing VS/HS/DE from VPS timing
module prt_vtb_tg #(
    parameter int P_PPC = 2
) (
    input  logic        CLK_IN,
    input  logic        RSTN_IN,
    input  logic        CKE_IN,
    input  logic        CTL_RUN_IN,
    input  logic [3:0]  VPS_IDX_IN,
    input  logic [15:0] VPS_DAT_IN,
    input  logic        VPS_VLD_IN,
    output logic        VID_VS_OUT,
    output logic        VID_HS_OUT,
    output logic        VID_DE_OUT,
    output logic        STA_RUN_OUT,
    output logic        STA_SOF_OUT
);

    // Horizontal timing is programmed in pixels; the counters run in clocks.
    localparam int SHIFT = (P_PPC == 4) ? 2 : 1;

    typedef struct packed {
        logic [1:0]  cfg;      // bit0: HS active-low, bit1: VS active-low
        logic [15:0] htotal;
        logic [15:0] hsw;
        logic [15:0] hstart;
        logic [15:0] hwidth;
        logic [15:0] vtotal;
        logic [15:0] vsw;
        logic [15:0] vstart;
        logic [15:0] vheight;
    } timing_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP
    } state_t;

    timing_t     shadow_q;
    timing_t     shadow_d;
    timing_t     active_q;
    state_t      state_q;
    state_t      state_d;
    logic        run_q;
    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic [15:0] htotal_c;
    logic [15:0] hsw_c;
    logic [15:0] hstart_c;
    logic [15:0] hwidth_c;
    logic [15:0] sh_htotal_c;
    logic [16:0] h_end;
    logic [16:0] v_end;
    logic        line_end;
    logic        frame_end;
    logic        start_ok;
    logic        hs_act;
    logic        vs_act;
    logic        de_act;

    assign htotal_c    = active_q.htotal >> SHIFT;
    assign hsw_c       = active_q.hsw >> SHIFT;
    assign hstart_c    = active_q.hstart >> SHIFT;
    assign hwidth_c    = active_q.hwidth >> SHIFT;
    assign sh_htotal_c = shadow_q.htotal >> SHIFT;

    assign line_end  = (hcnt == htotal_c - 16'd1);
    assign frame_end = line_end && (vcnt == active_q.vtotal - 16'd1);
    // Start is judged on the shadow set, since that is what gets loaded.
    assign start_ok  = run_q && (sh_htotal_c >= 16'd2) && (shadow_q.vtotal >= 16'd2);

    // Window ends are 17 bits wide so a large start+width never wraps.
    assign h_end  = {1'b0, hstart_c} + {1'b0, hwidth_c};
    assign v_end  = {1'b0, active_q.vstart} + {1'b0, active_q.vheight};
    assign hs_act = (hcnt < hsw_c);
    assign vs_act = (vcnt < active_q.vsw);
    assign de_act = (hcnt >= hstart_c) && ({1'b0, hcnt} < h_end) &&
                    (vcnt >= active_q.vstart) && ({1'b0, vcnt} < v_end);

    assign STA_RUN_OUT = (state_q != S_IDLE);

    // Shadow write decode; the result also feeds the end-of-frame reload.
    always_comb begin
        shadow_d = shadow_q;
        if (VPS_VLD_IN) begin
            case (VPS_IDX_IN)
                4'd0:    shadow_d.cfg     = VPS_DAT_IN[1:0];
                4'd1:    shadow_d.htotal  = VPS_DAT_IN;
                4'd2:    shadow_d.hsw     = VPS_DAT_IN;
                4'd3:    shadow_d.hstart  = VPS_DAT_IN;
                4'd5:    shadow_d.hwidth  = VPS_DAT_IN;
                4'd6:    shadow_d.vtotal  = VPS_DAT_IN;
                4'd7:    shadow_d.vsw     = VPS_DAT_IN;
                4'd8:    shadow_d.vstart  = VPS_DAT_IN;
                4'd9:    shadow_d.vheight = VPS_DAT_IN;
                default: ;
            endcase
        end
    end

    // Run/stop sequencing: stopping only completes at a frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (!run_q) state_d = S_STOP;
            S_STOP: begin
                if (frame_end)  state_d = S_IDLE;
                else if (run_q) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shadow registers and run request sampling are not clock-enabled.
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            shadow_q <= '0;
            run_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            run_q    <= CTL_RUN_IN;
        end
    end

    // State register advances only on enabled cycles.
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            state_q <= S_IDLE;
        end else if (CKE_IN) begin
            state_q <= state_d;
        end
    end

    // Raster counters and active timing, reloaded at start and at every frame end.
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            hcnt     <= '0;
            vcnt     <= '0;
            active_q <= '0;
        end else if (CKE_IN) begin
            if (state_q == S_IDLE) begin
                hcnt <= '0;
                vcnt <= '0;
                if (state_d == S_RUN) active_q <= shadow_q;
            end else if (line_end) begin
                hcnt <= '0;
                if (frame_end) begin
                    vcnt     <= '0;
                    active_q <= shadow_d;
                end else begin
                    vcnt <= vcnt + 16'd1;
                end
            end else begin
                hcnt <= hcnt + 16'd1;
            end
        end
    end

    // Registered video outputs; idle syncs sit at the programmed inactive level.
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            VID_HS_OUT  <= 1'b0;
            VID_VS_OUT  <= 1'b0;
            VID_DE_OUT  <= 1'b0;
            STA_SOF_OUT <= 1'b0;
        end else if (CKE_IN) begin
            if (state_q == S_IDLE) begin
                VID_HS_OUT  <= shadow_q.cfg[0];
                VID_VS_OUT  <= shadow_q.cfg[1];
                VID_DE_OUT  <= 1'b0;
                STA_SOF_OUT <= 1'b0;
            end else begin
                VID_HS_OUT  <= hs_act ^ active_q.cfg[0];
                VID_VS_OUT  <= vs_act ^ active_q.cfg[1];
                VID_DE_OUT  <= de_act;
                STA_SOF_OUT <= (hcnt == 16'd0) && (vcnt == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_prt_vtb_tg.sv
// tb/tb_prt_vtb_tg.sv - self-checking bench for prt_vtb_tg
module tb_prt_vtb_tg;

    localparam int PPC = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cke;
    logic        run;
    logic [3:0]  idx;
    logic [15:0] dat;
    logic        vld;
    logic        vs2, hs2, de2, run2, sof2;
    logic        vs4, hs4, de4, run4, sof4;

    int n_pass  = 0;
    int n_total = 0;

    prt_vtb_tg #(.P_PPC(2)) dut (
        .CLK_IN(clk), .RSTN_IN(rstn), .CKE_IN(cke), .CTL_RUN_IN(run),
        .VPS_IDX_IN(idx), .VPS_DAT_IN(dat), .VPS_VLD_IN(vld),
        .VID_VS_OUT(vs2), .VID_HS_OUT(hs2), .VID_DE_OUT(de2),
        .STA_RUN_OUT(run2), .STA_SOF_OUT(sof2)
    );

    prt_vtb_tg #(.P_PPC(4)) dut4 (
        .CLK_IN(clk), .RSTN_IN(rstn), .CKE_IN(cke), .CTL_RUN_IN(run),
        .VPS_IDX_IN(idx), .VPS_DAT_IN(dat), .VPS_VLD_IN(vld),
        .VID_VS_OUT(vs4), .VID_HS_OUT(hs4), .VID_DE_OUT(de4),
        .STA_RUN_OUT(run4), .STA_SOF_OUT(sof4)
    );

    always #5 clk = ~clk;

    // Reference model: frame position is one linear pixel-clock index.
    logic [15:0] m_sh  [16];
    logic [15:0] m_act [16];
    bit          m_runq;
    int          m_mode;   // 0 idle, 1 run, 2 stopping
    int          m_t;
    bit          e_vs, e_hs, e_de, e_sof;

    typedef struct {
        logic [15:0] cfg, ht, hsw, hst, hw, vt, vsw, vst, vh;
        int          exp_hs, exp_vs, exp_de, exp_per;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int hc(input logic [15:0] v);
        return int'(v) / PPC;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_runq = 0; m_mode = 0; m_t = 0;
        e_vs = 0; e_hs = 0; e_de = 0; e_sof = 0;
    endtask

    task automatic model_step();
        logic [15:0] nsh [16];
        int htc, vt, h, v;
        bit eof;
        nsh = m_sh;
        if (vld) nsh[idx] = dat;
        if (cke) begin
            if (m_mode == 0) begin
                e_hs = m_sh[0][0]; e_vs = m_sh[0][1]; e_de = 0; e_sof = 0;
                if (m_runq && hc(m_sh[1]) >= 2 && int'(m_sh[6]) >= 2) begin
                    m_mode = 1; m_act = m_sh; m_t = 0;
                end
            end else begin
                htc = hc(m_act[1]);
                vt  = int'(m_act[6]);
                h   = m_t % htc;
                v   = m_t / htc;
                e_hs  = (h < hc(m_act[2])) ^ m_act[0][0];
                e_vs  = (v < int'(m_act[7])) ^ m_act[0][1];
                e_de  = (h >= hc(m_act[3])) && (h < hc(m_act[3]) + hc(m_act[5])) &&
                        (v >= int'(m_act[8])) && (v < int'(m_act[8]) + int'(m_act[9]));
                e_sof = (m_t == 0);
                eof   = (m_t == htc * vt - 1);
                if (eof) begin m_t = 0; m_act = nsh; end
                else m_t++;
                if (m_mode == 1) begin
                    if (!m_runq) m_mode = 2;
                end else begin
                    if (eof) m_mode = 0;
                    else if (m_runq) m_mode = 1;
                end
            end
        end
        m_runq = run;
        m_sh   = nsh;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cycle", {27'd0, vs2, hs2, de2, run2, sof2},
            {27'd0, e_vs, e_hs, e_de, (m_mode != 0), e_sof});
    endtask

    task automatic wvps(input logic [3:0] i, input logic [15:0] d);
        vld = 1; idx = i; dat = d;
        tick();
        vld = 0;
    endtask

    task automatic prog(input vec_t t);
        wvps(4'd0, t.cfg); wvps(4'd1, t.ht);  wvps(4'd2, t.hsw);
        wvps(4'd3, t.hst); wvps(4'd5, t.hw);  wvps(4'd6, t.vt);
        wvps(4'd7, t.vsw); wvps(4'd8, t.vst); wvps(4'd9, t.vh);
    endtask

    task automatic wait_idle();
        int g = 0;
        run = 0;
        tick();
        while ((run2 || run4) && g < 2000) begin tick(); g++; end
        if (run2 || run4) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic restart(input vec_t t);
        wait_idle();
        prog(t);
        run = 1;
    endtask

    // Counts active sync/DE clocks over one SOF-to-SOF frame; optional write at an offset.
    task automatic measure(input bit gate, input logic [1:0] pol, input int wr_at,
                           input logic [3:0] widx, input logic [15:0] wdat,
                           output int nh, output int nv, output int nd, output int per);
        int  g = 0;
        bit  prev;
        nh = 0; nv = 0; nd = 0; per = 0;
        prev = sof2;
        while (!(sof2 && !prev) && g < 1000) begin
            prev = sof2;
            if (gate) cke = ~cke;
            tick();
            g++;
        end
        if (!sof2) begin
            chk("sof_timeout", 32'd0, 32'd1);
            return;
        end
        prev = 1;
        do begin
            nh += int'(hs2 ^ pol[0]);
            nv += int'(vs2 ^ pol[1]);
            nd += int'(de2);
            per++;
            if (per - 1 == wr_at) begin vld = 1; idx = widx; dat = wdat; end
            prev = sof2;
            if (gate) cke = ~cke;
            tick();
            vld = 0;
        end while (!(sof2 && !prev) && per < 1000);
    endtask

    task automatic wait_sof2();
        int g = 0;
        bit prev = sof2;
        while (!(sof2 && !prev) && g < 1000) begin prev = sof2; tick(); g++; end
        if (!sof2) chk("sof2_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int nh, nv, nd, per, off, cnt;
        bit stayed;

        //           cfg  ht  hsw hst hw vt vsw vst vh   hs  vs  de  per
        tbl[0] = '{16'd0, 20, 4, 6, 8, 6, 1, 2, 3,    12, 10, 12, 60};
        tbl[1] = '{16'd0, 20, 0, 6, 0, 6, 1, 2, 3,     0, 10,  0, 60};
        tbl[2] = '{16'd0, 20, 4, 16, 8, 6, 0, 4, 5,   12,  0,  4, 60};
        tbl[3] = '{16'd3, 20, 4, 6, 8, 6, 1, 2, 3,    12, 10, 12, 60};
        tbl[4] = '{16'd0, 21, 5, 7, 9, 4, 2, 0, 4,     8, 20, 16, 40};

        rstn = 0; cke = 1; run = 0; vld = 0; idx = '0; dat = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, vs2, hs2, de2, run2, sof2}, 32'd0);
        chk("reset_outputs4", {27'd0, vs4, hs4, de4, run4, sof4}, 32'd0);
        rstn = 1;

        // Timing table: one SOF-to-SOF frame per entry
        for (int i = 0; i < 5; i++) begin
            restart(tbl[i]);
            measure(0, tbl[i].cfg[1:0], -1, 4'd0, 16'd0, nh, nv, nd, per);
            chk($sformatf("tbl%0d_hs", i), nh, tbl[i].exp_hs);
            chk($sformatf("tbl%0d_vs", i), nv, tbl[i].exp_vs);
            chk($sformatf("tbl%0d_de", i), nd, tbl[i].exp_de);
            chk($sformatf("tbl%0d_period", i), per, tbl[i].exp_per);
        end

        // Frame-aligned update of hwidth
        restart(tbl[0]);
        measure(0, 2'd0, 5, 4'd5, 16'd12, nh, nv, nd, per);
        chk("upd_cur_de", nd, 12);
        measure(0, 2'd0, -1, 4'd0, 16'd0, nh, nv, nd, per);
        chk("upd_next_de", nd, 18);
        wvps(4'd5, 16'd8);

        // Stop at vcnt=1: frame completes, run status falls with the last pixel
        wait_sof2();
        off = 0;
        while (run2 && off < 200) begin
            off++;
            if (off == 12) run = 0;
            tick();
        end
        chk("stop_offset", off, 59);
        tick();
        chk("stop_idle_out", {29'd0, vs2, hs2, de2}, 32'd0);

        // Drop and re-raise before EOF: no gap
        run = 1;
        wait_sof2();
        off = 0; stayed = 1;
        do begin
            off++;
            if (off == 12) run = 0;
            if (off == 30) run = 1;
            tick();
            if (!run2) stayed = 0;
        end while (!sof2 && off < 200);
        chk("rerun_period", off, 60);
        chk("rerun_no_gap", stayed, 1);

        // Clock-enable gating doubles every duration
        measure(1, 2'd0, -1, 4'd0, 16'd0, nh, nv, nd, per);
        chk("cke_period", per, 120);
        chk("cke_hs", nh, 24);
        chk("cke_de", nd, 24);
        cke = 1;

        // P_PPC=4 instance, inverted syncs
        wait_idle();
        prog('{16'd3, 40, 8, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0});
        tick();
        chk("p4_idle_high", {30'd0, vs4, hs4}, 32'd3);
        run = 1;
        cnt = 0;
        while (!sof4 && cnt < 200) begin tick(); cnt++; end
        chk("p4_sof_vs_low", {30'd0, sof4, vs4}, 32'd2);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cnt += int'(!hs4);
            tick();
        end
        chk("p4_hs_low", cnt, 2);

        // Invalid timing: vtotal=1 never leaves idle
        wait_idle();
        prog('{16'd0, 20, 4, 6, 8, 1, 1, 2, 3, 0, 0, 0, 0});
        run = 1;
        repeat (20) tick();
        chk("inv_idle", {26'd0, vs2, hs2, de2, run2, vs4, hs4}, 32'd0);
        chk("inv_run4", run4, 0);

        // Asynchronous reset mid-line
        wait_idle();
        restart(tbl[3]);
        wait_sof2();
        repeat (15) tick();
        @(posedge clk);
        #2 rstn = 0;
        #1;
        chk("rst_now2", {27'd0, vs2, hs2, de2, run2, sof2}, 32'd0);
        chk("rst_now4", {27'd0, vs4, hs4, de4, run4, sof4}, 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1;
        repeat (10) tick();
        chk("rst_stay_idle", {29'd0, run2, hs2, vs2}, 32'd0);
        prog(tbl[0]);
        cnt = 0;
        while (!run2 && cnt < 50) begin tick(); cnt++; end
        chk("rst_restart", run2, 1);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cke = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            if ($urandom_range(0, 9) == 0) begin
                vld = 1;
                idx = 4'($urandom_range(0, 15));
                case (idx)
                    4'd0:    dat = 16'($urandom_range(0, 3));
                    4'd1:    dat = 16'($urandom_range(8, 40));
                    4'd2:    dat = 16'($urandom_range(0, 12));
                    4'd3:    dat = 16'($urandom_range(0, 30));
                    4'd5:    dat = 16'($urandom_range(0, 30));
                    4'd6:    dat = 16'($urandom_range(2, 8));
                    4'd7:    dat = 16'($urandom_range(0, 4));
                    4'd8:    dat = 16'($urandom_range(0, 8));
                    4'd9:    dat = 16'($urandom_range(0, 8));
                    default: dat = 16'($urandom);
                endcase
            end
            tick();
            vld = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
